// File: rtl/hdc_pkg.sv
// Shared sizing and types for the HDC sample loader.
package hdc_pkg;

  localparam int FEATURE_COUNT = 617;
  localparam int FEATURE_W     = 16;
  localparam int CLASS_W       = 5;
  localparam int NUM_CLASSES   = 26;
  localparam int CNT_W         = 11;

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    LAUNCH,
    WAIT,
    DONE
  } loader_state_t;

  typedef logic [FEATURE_W-1:0] feature_t;

endpackage

// File: rtl/hdc_sample_loader.sv
// Stream-to-parallel sample assembler feeding oneshot_hdc_top, with dataset phase sequencing.
// Optional: LOADER_LABEL_CHECK_EN rejects labels >= NUM_CLASSES as framing errors.
module hdc_sample_loader #(
  parameter int FEATURE_COUNT = hdc_pkg::FEATURE_COUNT,
  parameter int FEATURE_W     = hdc_pkg::FEATURE_W,
  parameter int CLASS_W       = hdc_pkg::CLASS_W,
  parameter int NUM_CLASSES   = hdc_pkg::NUM_CLASSES
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    en,
  input  logic                                    s_valid,
  output logic                                    s_ready,
  input  logic [FEATURE_W-1:0]                    s_data,
  input  logic                                    s_last,
  input  logic [CLASS_W-1:0]                      s_label,
  input  logic                                    dataset_end,
  input  logic                                    sample_done,
  output logic [FEATURE_COUNT-1:0][FEATURE_W-1:0] input_values,
  output logic [CLASS_W-1:0]                      class_select_bits,
  output logic                                    start_mapping,
  output logic                                    training_dataset_finished,
  output logic                                    testing_dataset_finished,
  output logic [10:0]                             samples_loaded,
  output logic                                    frame_err
);
  import hdc_pkg::*;

  localparam int IDX_W = (FEATURE_COUNT > 1) ? $clog2(FEATURE_COUNT) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FEATURE_COUNT - 1);

  loader_state_t    state;
  logic [IDX_W-1:0] idx;
  logic             hs;
  logic             label_ok;

  assign s_ready = en & ((state == IDLE) | (state == FILL));
  assign hs      = s_valid & s_ready;

`ifdef LOADER_LABEL_CHECK_EN
  assign label_ok = (int'(s_label) < NUM_CLASSES);
`else
  assign label_ok = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state                     <= IDLE;
      idx                       <= '0;
      input_values              <= '0;
      class_select_bits         <= '0;
      start_mapping             <= 1'b0;
      training_dataset_finished <= 1'b0;
      testing_dataset_finished  <= 1'b0;
      samples_loaded            <= '0;
      frame_err                 <= 1'b0;
    end else if (en) begin
      start_mapping <= 1'b0;
      case (state)
        IDLE, FILL: begin
          if (hs) begin
            input_values[idx] <= s_data;
            if (idx == LAST_IDX) begin
              idx <= '0;
              if (s_last && label_ok) begin
                class_select_bits <= s_label;
                start_mapping     <= 1'b1;
                state             <= LAUNCH;
              end else begin
                frame_err <= 1'b1;
                state     <= IDLE;
              end
            end else if (s_last) begin
              // short sample: drop it and resynchronise on the next beat
              frame_err <= 1'b1;
              idx       <= '0;
              state     <= IDLE;
            end else begin
              idx   <= idx + 1'b1;
              state <= FILL;
            end
          end else if ((state == IDLE) && dataset_end) begin
            if (!training_dataset_finished) begin
              training_dataset_finished <= 1'b1;
              samples_loaded            <= '0;
            end else begin
              testing_dataset_finished <= 1'b1;
              state                    <= DONE;
            end
          end
        end
        LAUNCH: begin
          if (samples_loaded != '1) samples_loaded <= samples_loaded + 1'b1;
          state <= WAIT;
        end
        WAIT: begin
          if (sample_done) state <= IDLE;
        end
        DONE: state <= DONE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
